// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised synchronous RAM.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;
    localparam int BYTE_W       = 8;

    function automatic int lanes(input int data_w);
        return data_w / BYTE_W;
    endfunction

    // Even parity: stored bit makes the 9-bit group have an even number of ones.
    function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset zero-clear sequencer: sweeps every word once, then opens the RAM for requests.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;

    // Clear walk and ready flag; reset restarts the walk from word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_ptr == LAST_ADDR) begin
                        state   <= ST_IDLE;
                        clr_ptr <= '0;
                        ready   <= 1'b1;
                    end else begin
                        clr_ptr <= clr_ptr + ADDR_W'(1);
                        ready   <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    ready <= 1'b1;
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_ptr <= '0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    // No clear write happens in the reset cycle itself, so memory is untouched by rst.
    assign clr_we   = (state == ST_CLEAR) && !rst;
    assign clr_addr = clr_ptr;

endmodule

// File: rtl/ram_sync_param.sv
// Parametrised synchronous single-port RAM with byte enables, zero-clear and range check.
// Optional per-byte even parity when RAM_PARITY_EN is defined.
module ram_sync_param
    import ram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int READ_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    writeOn,
    input  logic [ADDR_W-1:0]       address,
    input  logic [DATA_W-1:0]       data_in,
    input  logic [DATA_W/8-1:0]     byte_en,
    output logic                    ready,
    output logic [DATA_W-1:0]       data_out,
    output logic                    data_valid,
    output logic                    addr_err,
    output logic                    parity_err
);

    localparam int LANES = lanes(DATA_W);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
        $error("ram_sync_param: READ_LAT must be 1 or 2");
    end
    if ((DATA_W % BYTE_W) != 0 || DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_geom
        $error("ram_sync_param: illegal DATA_W/DEPTH");
    end

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              accept;
    logic              in_range;
    logic              rd_acc;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_data;
    logic              rd_perr;

    logic [DATA_W-1:0] mem [DEPTH];

    ram_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign accept   = req && ready && !rst;
    assign in_range = ({1'b0, address} < DEPTH_V);
    assign rd_acc   = accept && !writeOn;
    assign wr_ok    = accept && writeOn && in_range;
    assign rd_data  = in_range ? mem[address] : '0;

    // Storage: the clear sweep owns the port while active, otherwise byte-lane merge.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < LANES; b++) begin
                if (byte_en[b]) begin
                    mem[address][b*BYTE_W +: BYTE_W] <= data_in[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic [LANES-1:0] par_mem [DEPTH];

    // Parity shadow follows the data array lane by lane.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < LANES; b++) begin
                if (byte_en[b]) begin
                    par_mem[address][b] <= byte_parity(data_in[b*BYTE_W +: BYTE_W]);
                end
            end
        end
    end

    // Recompute parity on the word being read and compare against the shadow.
    always_comb begin
        rd_perr = 1'b0;
        if (in_range) begin
            for (int b = 0; b < LANES; b++) begin
                if (byte_parity(mem[address][b*BYTE_W +: BYTE_W]) != par_mem[address][b]) begin
                    rd_perr = 1'b1;
                end
            end
        end else begin
            rd_perr = 1'b0;
        end
    end
`else
    assign rd_perr = 1'b0;
`endif

    logic [READ_LAT-1:0] v_r;
    logic [READ_LAT-1:0] pe_r;
    logic [DATA_W-1:0]   d_r [READ_LAT];

    // Read pipeline; a data stage only reloads when a result passes, so data_out holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r      <= '0;
            pe_r     <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                d_r[i] <= '0;
            end
            addr_err <= 1'b0;
        end else begin
            v_r[0]  <= rd_acc;
            pe_r[0] <= rd_acc && rd_perr;
            if (rd_acc) begin
                d_r[0] <= rd_data;
            end
            for (int i = 1; i < READ_LAT; i++) begin
                v_r[i]  <= v_r[i-1];
                pe_r[i] <= pe_r[i-1];
                if (v_r[i-1]) begin
                    d_r[i] <= d_r[i-1];
                end
            end
            addr_err <= accept && !in_range;
        end
    end

    assign data_out   = d_r[READ_LAT-1];
    assign data_valid = v_r[READ_LAT-1];
    assign parity_err = pe_r[READ_LAT-1];

endmodule

// File: tb/tb_ram_sync_param.sv
// Bench for ram_sync_param: instance 0 is 32 words / latency 1, instance 1 is 20 words / latency 2.
module tb_ram_sync_param;

`ifdef RAM_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic [1:0]  rst, req, wr, rdy, dval, aerr, perr;
    logic [4:0]  addr [2];
    logic [31:0] din  [2];
    logic [3:0]  be   [2];
    logic [31:0] dout [2];

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_sync_param #(
            .DATA_W   (32),
            .ADDR_W   (5),
            .DEPTH    ((g == 0) ? 32 : 20),
            .READ_LAT ((g == 0) ? 1 : 2)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req        (req[g]),
            .writeOn    (wr[g]),
            .address    (addr[g]),
            .data_in    (din[g]),
            .byte_en    (be[g]),
            .ready      (rdy[g]),
            .data_out   (dout[g]),
            .data_valid (dval[g]),
            .addr_err   (aerr[g]),
            .parity_err (perr[g])
        );
    end

    function automatic int dep(input int g);
        return (g == 0) ? 32 : 20;
    endfunction

    function automatic int lat(input int g);
        return (g == 0) ? 1 : 2;
    endfunction

    task automatic check(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h t=%0t", nm, g, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          inst;
        int          due;
        logic [31:0] d;
        logic        pe;
    } rd_t;

    rd_t         pend [$];
    logic [31:0] mm   [2][32];
    logic [3:0]  mpar [2][32];
    int          clr_left [2];
    int          cyc = 0;
    logic [1:0]  e_rdy = 2'b00, e_val = 2'b00, e_aerr = 2'b00, e_perr = 2'b00;
    logic [31:0] e_dout [2];

    always @(posedge clk) begin
        cyc++;
        for (int g = 0; g < 2; g++) begin
            if (rst[g]) begin
                clr_left[g] = dep(g);
                e_rdy[g] = 1'b0; e_val[g] = 1'b0; e_aerr[g] = 1'b0; e_perr[g] = 1'b0;
                e_dout[g] = 32'h0;
                for (int i = pend.size() - 1; i >= 0; i--)
                    if (pend[i].inst == g) pend.delete(i);
            end else begin
                bit acc, oor, pe;
                rd_t r;
                acc = req[g] && e_rdy[g];
                oor = int'(addr[g]) >= dep(g);
                e_aerr[g] = acc && oor;
                e_val[g]  = 1'b0;
                e_perr[g] = 1'b0;
                if (acc && !wr[g]) begin
                    pe = 1'b0;
                    if (!oor && PAR_ON)
                        for (int b = 0; b < 4; b++)
                            if ((^mm[g][addr[g]][b*8 +: 8]) != mpar[g][addr[g]][b]) pe = 1'b1;
                    r.inst = g; r.due = cyc + lat(g) - 1;
                    r.d = oor ? 32'h0 : mm[g][addr[g]]; r.pe = pe;
                    pend.push_back(r);
                end
                if (acc && wr[g] && !oor)
                    for (int b = 0; b < 4; b++)
                        if (be[g][b]) begin
                            mm[g][addr[g]][b*8 +: 8] = din[g][b*8 +: 8];
                            mpar[g][addr[g]][b] = ^din[g][b*8 +: 8];
                        end
                if (clr_left[g] > 0) begin
                    mm[g][dep(g) - clr_left[g]] = 32'h0;
                    mpar[g][dep(g) - clr_left[g]] = 4'h0;
                    clr_left[g]--;
                    if (clr_left[g] == 0) e_rdy[g] = 1'b1;
                end
                for (int i = 0; i < pend.size(); i++)
                    if (pend[i].inst == g) begin
                        if (pend[i].due == cyc) begin
                            e_val[g] = 1'b1; e_dout[g] = pend[i].d; e_perr[g] = pend[i].pe;
                            pend.delete(i);
                        end
                        break;
                    end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int g = 0; g < 2; g++) begin
                check("ready",      g, 32'(rdy[g]),  32'(e_rdy[g]));
                check("data_valid", g, 32'(dval[g]), 32'(e_val[g]));
                check("addr_err",   g, 32'(aerr[g]), 32'(e_aerr[g]));
                check("parity_err", g, 32'(perr[g]), 32'(e_perr[g]));
                check("data_out",   g, dout[g],      e_dout[g]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input int g, input bit w, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        req[g] = 1'b1; wr[g] = w; addr[g] = a; din[g] = d; be[g] = b;
        @(negedge clk);
        req[g] = 1'b0; wr[g] = 1'b0;
    endtask

    task automatic wait_ready(input int g, input int want, input string nm);
        int n = 0;
        while (!rdy[g] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(nm, g, 32'(n), 32'(want));
    endtask

    initial begin
        rst = 2'b11; req = 2'b00; wr = 2'b00;
        for (int g = 0; g < 2; g++) begin
            addr[g] = 5'd0; din[g] = 32'h0; be[g] = 4'h0;
        end
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        check("reset_ready", 0, 32'(rdy[0]), 32'h0);
        check("reset_dout",  0, dout[0], 32'h0);

        // Clear length with req held high, then every word reads as zero.
        rst = 2'b00;
        req[0] = 1'b1;
        wait_ready(0, 32, "t1_clear_len");
        for (int a = 0; a < 32; a++) begin
            drive(0, 1'b0, 5'(a), 32'h0, 4'h0);
            check("t1_valid", 0, 32'(dval[0]), 32'h1);
            check("t1_zero",  0, dout[0], 32'h0);
        end

        // Byte-lane merge, read-after-write, byte_en=0 no-op.
        drive(0, 1'b1, 5'd5, 32'hDEADBEEF, 4'b1111);
        drive(0, 1'b1, 5'd5, 32'h11223344, 4'b0101);
        drive(0, 1'b0, 5'd5, 32'h0, 4'h0);
        check("t2_merge", 0, dout[0], 32'hDE22BE44);
        drive(0, 1'b1, 5'd5, 32'hFFFFFFFF, 4'b0000);
        drive(0, 1'b0, 5'd5, 32'h0, 4'h0);
        check("t2_noop", 0, dout[0], 32'hDE22BE44);

        // Latency-2 back-to-back reads.
        drive(1, 1'b1, 5'd1, 32'hA1, 4'hF);
        drive(1, 1'b1, 5'd2, 32'hA2, 4'hF);
        drive(1, 1'b1, 5'd3, 32'hA3, 4'hF);
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 5'd1;
        @(negedge clk);
        check("t3_gap", 1, 32'(dval[1]), 32'h0);
        addr[1] = 5'd2;
        @(negedge clk);
        check("t3_d1", 1, dout[1], 32'hA1);
        addr[1] = 5'd3;
        @(negedge clk);
        check("t3_d2", 1, dout[1], 32'hA2);
        req[1] = 1'b0;
        @(negedge clk);
        check("t3_d3", 1, dout[1], 32'hA3);
        check("t3_v3", 1, 32'(dval[1]), 32'h1);
        @(negedge clk);
        check("t3_end", 1, 32'(dval[1]), 32'h0);

        // Out-of-range accesses on the 20-word instance.
        drive(1, 1'b1, 5'd5, 32'h00000055, 4'hF);
        check("t4_inrange_err", 1, 32'(aerr[1]), 32'h0);
        drive(1, 1'b1, 5'd25, 32'hFFFFFFFF, 4'hF);
        check("t4_werr", 1, 32'(aerr[1]), 32'h1);
        drive(1, 1'b0, 5'd25, 32'h0, 4'h0);
        check("t4_rerr", 1, 32'(aerr[1]), 32'h1);
        @(negedge clk);
        check("t4_rvalid", 1, 32'(dval[1]), 32'h1);
        check("t4_rzero",  1, dout[1], 32'h0);
        drive(1, 1'b0, 5'd5, 32'h0, 4'h0);
        @(negedge clk);
        check("t4_alias", 1, dout[1], 32'h00000055);

        // Reset mid-clear restarts the sweep.
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        repeat (10) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        wait_ready(0, 32, "t5_restart_len");
        drive(0, 1'b0, 5'd5, 32'h0, 4'h0);
        check("t5_cleared", 0, dout[0], 32'h0);

        // Reset with a latency-2 read in flight.
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 5'd1;
        @(negedge clk);
        req[1] = 1'b0; rst[1] = 1'b1;
        @(negedge clk);
        check("t5_flush", 1, 32'(dval[1]), 32'h0);
        rst[1] = 1'b0;
        wait_ready(1, 20, "t5_clear20");

`ifdef RAM_PARITY_EN
        drive(0, 1'b1, 5'd3, 32'h000000FF, 4'hF);
        g_dut[0].u_dut.mem[3][0] = 1'b0;
        mm[0][3][0] = 1'b0;
        drive(0, 1'b0, 5'd3, 32'h0, 4'h0);
        check("t6_data", 0, dout[0], 32'h000000FE);
        check("t6_perr", 0, 32'(perr[0]), 32'h1);
`endif

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
